instruction_fetch: RTL and testbench

IF stage of the 5-stage pipelined RV64 subset core (R-type, ld, sd, beq). Owns the PC register, the internal instruction ROM and the IF/ID pipeline register. Produces inst_id/PC_id for the decode stage. Consumes the decode stage's stall (PCnotWrite, IFIDnotWrite), flush (IFIDflush) and redirect (PCSrc, PCbranch_id) controls.

---
 rtl/instruction_fetch.sv | 112 +++++++++++
 tb/tb_instruction_fetch.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage of the 5-stage RV64 subset core; owns the PC, the byte-wide
//   instruction ROM and the IF/ID pipeline register.
// Latency: the word at PC p appears on inst_id one cycle after pc_if==p (no stall/flush).
// Backpressure: PCnotWrite / IFIDnotWrite hold their register; IFIDflush inserts a bubble.
//
// Ports:
//   clk, reset            pipeline clock, asynchronous active-high reset
//   PCnotWrite            hold the PC (load-use stall); also masks PCSrc
//   IFIDnotWrite          hold IF/ID (load-use stall); also masks IFIDflush
//   IFIDflush             squash the word being fetched (taken beq in ID)
//   PCSrc, PCbranch_id    redirect the next PC to the branch target
//   pc_if                 current fetch PC
//   inst_id, PC_id        IF/ID instruction and its PC
//   valid_id              IF/ID holds a real instruction (not a bubble)
//   halted                sticky end-of-program flag (valid all-zero word reached ID)
// Optional: define FETCH_PERF_EN to add saturating counters perf_fetched, perf_stalled,
//   perf_flushed (all frozen while halted).
module instruction_fetch #(
  parameter int          IMEM_BYTES = 1024,
  parameter string       IMEM_FILE  = "instructions.txt",
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCnotWrite,
  input  logic        IFIDnotWrite,
  input  logic        IFIDflush,
  input  logic        PCSrc,
  input  logic [63:0] PCbranch_id,
  output logic [63:0] pc_if,
  output logic [31:0] inst_id,
  output logic [63:0] PC_id,
  output logic        valid_id,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalled,
  output logic [31:0] perf_flushed,
`endif
  output logic        halted
);

  localparam int AW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;

  logic [7:0] mem [0:IMEM_BYTES-1];

  logic          fetch_ok;
  logic [AW-1:0] fetch_addr;
  logic [31:0]   fetch_word;

  // Compare against IMEM_BYTES-4 rather than computing pc+3, which would wrap near 2^64.
  assign fetch_ok   = (pc_if[1:0] == 2'b00) && (pc_if <= 64'(IMEM_BYTES - 4));
  assign fetch_addr = pc_if[AW-1:0];

  always_comb begin
    fetch_word = 32'h0;
    if (fetch_ok) begin
      fetch_word = {mem[fetch_addr + AW'(3)], mem[fetch_addr + AW'(2)],
                    mem[fetch_addr + AW'(1)], mem[fetch_addr]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_if    <= RESET_PC;
      inst_id  <= 32'h0;
      PC_id    <= 64'h0;
      valid_id <= 1'b0;
      halted   <= 1'b0;
    end else if (!halted) begin
      // Under a load-use stall the branch operands are stale, so PCSrc is ignored.
      if (!PCnotWrite) begin
        pc_if <= PCSrc ? PCbranch_id : pc_if + 64'd4;
      end
      if (!IFIDnotWrite) begin
        if (IFIDflush) begin
          inst_id  <= 32'h0;
          PC_id    <= 64'h0;
          valid_id <= 1'b0;
        end else begin
          inst_id  <= fetch_word;
          PC_id    <= pc_if;
          valid_id <= 1'b1;
        end
      end
      // A wrong-path zero word being flushed must not end the program.
      if (valid_id && (inst_id == 32'h0) && !IFIDflush) begin
        halted <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic load_valid;
  logic flush_taken;

  assign load_valid  = !IFIDnotWrite && !IFIDflush;
  assign flush_taken = !IFIDnotWrite && IFIDflush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= 32'h0;
      perf_stalled <= 32'h0;
      perf_flushed <= 32'h0;
    end else if (!halted) begin
      if (load_valid && (perf_fetched != 32'hFFFF_FFFF)) perf_fetched <= perf_fetched + 32'd1;
      if (PCnotWrite && (perf_stalled != 32'hFFFF_FFFF)) perf_stalled <= perf_stalled + 32'd1;
      if (flush_taken && (perf_flushed != 32'hFFFF_FFFF)) perf_flushed <= perf_flushed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: self-checking bench for instruction_fetch.
// Expected per-cycle outputs are queued when stimulus is driven and compared after the edge.
// ROM contents are written directly into the DUT memory at time 0.
module tb_instruction_fetch;

  localparam int IMEM_BYTES = 1024;

  localparam logic [31:0] W_A = 32'h002081b3;
  localparam logic [31:0] W_B = 32'h00208e63;
  localparam logic [31:0] W_C = 32'h0041b023;
  localparam logic [31:0] W_D = 32'h003100b3;
  localparam logic [31:0] W_E = 32'h40208133;
  localparam logic [31:0] W_F = 32'h0020f1b3;

  logic        clk;
  logic        reset;
  logic        PCnotWrite;
  logic        IFIDnotWrite;
  logic        IFIDflush;
  logic        PCSrc;
  logic [63:0] PCbranch_id;
  logic [63:0] pc_if;
  logic [31:0] inst_id;
  logic [63:0] PC_id;
  logic        valid_id;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalled;
  logic [31:0] perf_flushed;
`endif

  instruction_fetch #(
    .IMEM_BYTES(IMEM_BYTES),
    .IMEM_FILE (""),
    .RESET_PC  (64'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .PCnotWrite  (PCnotWrite),
    .IFIDnotWrite(IFIDnotWrite),
    .IFIDflush   (IFIDflush),
    .PCSrc       (PCSrc),
    .PCbranch_id (PCbranch_id),
    .pc_if       (pc_if),
    .inst_id     (inst_id),
    .PC_id       (PC_id),
    .valid_id    (valid_id),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched),
    .perf_stalled(perf_stalled),
    .perf_flushed(perf_flushed),
`endif
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] pcid;
    logic        valid;
    logic        halt;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] e_pc, input logic [31:0] e_inst,
                          input logic [63:0] e_pcid, input logic e_v, input logic e_h);
    exp_t e;
    e.pc = e_pc; e.inst = e_inst; e.pcid = e_pcid; e.valid = e_v; e.halt = e_h;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val({tag, ".sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, ".pc_if"},    pc_if,           e.pc);
      check_val({tag, ".inst_id"},  64'(inst_id),    64'(e.inst));
      check_val({tag, ".PC_id"},    PC_id,           e.pcid);
      check_val({tag, ".valid_id"}, 64'(valid_id),   64'(e.valid));
      check_val({tag, ".halted"},   64'(halted),     64'(e.halt));
    end
  endtask

  // Drive one cycle of controls, queue the state expected after the edge, then compare.
  task automatic step(input string tag, input logic pnw, input logic ifnw, input logic fl,
                      input logic src, input logic [63:0] tgt,
                      input logic [63:0] e_pc, input logic [31:0] e_inst,
                      input logic [63:0] e_pcid, input logic e_v, input logic e_h);
    PCnotWrite   = pnw;
    IFIDnotWrite = ifnw;
    IFIDflush    = fl;
    PCSrc        = src;
    PCbranch_id  = tgt;
    push_exp(e_pc, e_inst, e_pcid, e_v, e_h);
    @(posedge clk);
    #1;
    pop_cmp(tag);
  endtask

  task automatic idle_inputs();
    PCnotWrite = 1'b0; IFIDnotWrite = 1'b0; IFIDflush = 1'b0; PCSrc = 1'b0;
    PCbranch_id = 64'h0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    push_exp(64'h0, 32'h0, 64'h0, 1'b0, 1'b0);
    pop_cmp(tag);
    reset = 1'b0;
  endtask

  task automatic load_word(input int addr, input logic [31:0] w);
    for (int k = 0; k < 4; k++) dut.mem[addr + k] = w[8*k +: 8];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < IMEM_BYTES; i++) dut.mem[i] = 8'h00;
    load_word(0,    W_A);
    load_word(4,    W_B);
    load_word(8,    W_C);
    load_word(12,   32'h0);
    load_word(16,   W_D);
    load_word(32'h40, W_E);
    load_word(32'h44, W_F);
    load_word(32'h48, 32'h0);

    // Sequential fetch, load-use stall, halt on a valid zero word, freeze.
    do_reset("p1.reset");
    step("p1.e1",    0, 0, 0, 0, 64'h0,  64'd4,  W_A,   64'd0,  1, 0);
    step("p1.e2",    0, 0, 0, 0, 64'h0,  64'd8,  W_B,   64'd4,  1, 0);
    step("p1.stall", 1, 1, 0, 0, 64'h0,  64'd8,  W_B,   64'd4,  1, 0);
    step("p1.e4",    0, 0, 0, 0, 64'h0,  64'd12, W_C,   64'd8,  1, 0);
    step("p1.e5",    0, 0, 0, 0, 64'h0,  64'd16, 32'h0, 64'd12, 1, 0);
    step("p1.halt",  0, 0, 0, 0, 64'h0,  64'd20, W_D,   64'd16, 1, 1);
    for (int i = 0; i < 10; i++) begin
      step("p1.frozen", 0, 0, 1'(i % 2), 1, 64'h40, 64'd20, W_D, 64'd16, 1, 1);
    end
    // Asynchronous reset mid-cycle: outputs must clear before the next edge.
    #2;
    reset = 1'b1;
    #1;
    push_exp(64'h0, 32'h0, 64'h0, 1'b0, 1'b0);
    pop_cmp("p1.async_reset");
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;

    // Ignored redirect under stall, taken branch with one bubble, IF/ID-only stall.
    step("p2.e1",      0, 0, 0, 0, 64'h0,  64'd4,  W_A,   64'd0,  1, 0);
    step("p2.e2",      0, 0, 0, 0, 64'h0,  64'd8,  W_B,   64'd4,  1, 0);
    step("p2.stallbr", 1, 1, 1, 1, 64'h40, 64'd8,  W_B,   64'd4,  1, 0);
    step("p2.redir",   0, 0, 1, 1, 64'h40, 64'h40, 32'h0, 64'd0,  0, 0);
    step("p2.target",  0, 0, 0, 0, 64'h0,  64'h44, W_E,   64'h40, 1, 0);
    step("p2.t4",      0, 0, 0, 0, 64'h0,  64'h48, W_F,   64'h44, 1, 0);
    step("p2.ifidhold",0, 1, 0, 0, 64'h0,  64'h4C, W_F,   64'h44, 1, 0);
    step("p2.resume",  0, 0, 0, 0, 64'h0,  64'h50, 32'h0, 64'h4C, 1, 0);

    // Misaligned / out-of-range target fetches zero, which then halts.
    do_reset("p3.reset");
    step("p3.e1",     0, 0, 0, 0, 64'h0, 64'd4, W_A, 64'd0, 1, 0);
    step("p3.redir",  0, 0, 1, 1, 64'(IMEM_BYTES - 2), 64'(IMEM_BYTES - 2), 32'h0, 64'd0, 0, 0);
    step("p3.oor",    0, 0, 0, 0, 64'h0, 64'(IMEM_BYTES + 2), 32'h0, 64'(IMEM_BYTES - 2), 1, 0);
    step("p3.halt",   0, 0, 0, 0, 64'h0, 64'(IMEM_BYTES + 6), 32'h0, 64'(IMEM_BYTES + 2), 1, 1);
    step("p3.frozen", 0, 0, 0, 0, 64'h0, 64'(IMEM_BYTES + 6), 32'h0, 64'(IMEM_BYTES + 2), 1, 1);

    // Flushed zero word does not halt; PC wraps at 2^64.
    do_reset("p4.reset");
    step("p4.e1",      0, 0, 0, 0, 64'h0,  64'd4,  W_A,   64'd0,  1, 0);
    step("p4.redir12", 0, 0, 1, 1, 64'd12, 64'd12, 32'h0, 64'd0,  0, 0);
    step("p4.zero",    0, 0, 0, 0, 64'h0,  64'd16, 32'h0, 64'd12, 1, 0);
    step("p4.flushz",  0, 0, 1, 1, 64'h0,  64'd0,  32'h0, 64'd0,  0, 0);
    step("p4.e5",      0, 0, 0, 0, 64'h0,  64'd4,  W_A,   64'd0,  1, 0);
    step("p4.redirtop",0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC,
         32'h0, 64'd0, 0, 0);
    step("p4.wrap",    0, 0, 0, 0, 64'h0,  64'd0,  32'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0);
    step("p4.halt",    0, 0, 0, 0, 64'h0,  64'd4,  W_A,   64'd0,  1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
